// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// uart_cmd_pkg : parser state encoding and default framing constants
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_OPCODE  = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic [7:0] DEF_SYNC_BYTE   = 8'hA5;
  localparam int         DEF_MAX_PAYLOAD = 8;

endpackage

`default_nettype wire

// File: rtl/uart_byte_timer.sv
// ============================================================================
// uart_byte_timer : inter-byte silence counter with a one-cycle expire flag
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_byte_timer #(
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int             W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // A byte arriving on the expiring cycle suppresses the timeout.
  assign expire = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable || expire) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
// uart_cmd_parser : frames SYNC/OPCODE/LEN/PAYLOAD/CHK bytes into commands
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEF_SYNC_BYTE,
  parameter int         MAX_PAYLOAD    = DEF_MAX_PAYLOAD,
  parameter int         TIMEOUT_CYCLES = 25000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx_done,
  input  logic [7:0]               i_rx_byte,
  output logic                     o_cmd_valid,
  input  logic                     i_cmd_ready,
  output logic [7:0]               o_cmd_opcode,
  output logic [7:0]               o_cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] o_cmd_payload,
  output logic                     o_err_checksum,
  output logic                     o_err_len,
  output logic                     o_err_timeout,
  output logic                     o_overrun
);

  state_t     state, state_nxt;
  logic [7:0] idx;
  logic [7:0] xor_acc;
  logic       timer_en, timer_expire;
  logic       chk_err_nxt, len_err_nxt, to_err_nxt, ovr_nxt;

  assign timer_en    = (state == ST_OPCODE) || (state == ST_LEN) ||
                       (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign o_cmd_valid = (state == ST_HOLD);

  uart_byte_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (i_clk),
    .rst_n  (i_rst_n),
    .clear  (i_rx_done),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    chk_err_nxt = 1'b0;
    len_err_nxt = 1'b0;
    to_err_nxt  = 1'b0;
    ovr_nxt     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_rx_done && (i_rx_byte == SYNC_BYTE)) state_nxt = ST_OPCODE;
      end
      ST_OPCODE: begin
        if (i_rx_done) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (i_rx_done) begin
          if (i_rx_byte > 8'(MAX_PAYLOAD)) begin
            len_err_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end else if (i_rx_byte == 8'd0) begin
            state_nxt = ST_CHECK;
          end else begin
            state_nxt = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_done && (idx == o_cmd_len - 8'd1)) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (i_rx_done) begin
          if (i_rx_byte == xor_acc) begin
            state_nxt = ST_HOLD;
          end else begin
            chk_err_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        ovr_nxt = i_rx_done;
        if (i_cmd_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timer_expire) begin
      to_err_nxt = 1'b1;
      state_nxt  = ST_IDLE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_cmd_opcode   <= '0;
      o_cmd_len      <= '0;
      o_cmd_payload  <= '0;
      idx            <= '0;
      xor_acc        <= '0;
      o_err_checksum <= 1'b0;
      o_err_len      <= 1'b0;
      o_err_timeout  <= 1'b0;
      o_overrun      <= 1'b0;
    end else begin
      o_err_checksum <= chk_err_nxt;
      o_err_len      <= len_err_nxt;
      o_err_timeout  <= to_err_nxt;
      o_overrun      <= ovr_nxt;
      if (i_rx_done) begin
        unique case (state)
          ST_IDLE: xor_acc <= '0;
          ST_OPCODE: begin
            o_cmd_opcode  <= i_rx_byte;
            o_cmd_payload <= '0;
            xor_acc       <= i_rx_byte;
          end
          ST_LEN: begin
            o_cmd_len <= i_rx_byte;
            idx       <= '0;
            xor_acc   <= xor_acc ^ i_rx_byte;
          end
          ST_PAYLOAD: begin
            for (int k = 0; k < MAX_PAYLOAD; k++) begin
              if (idx == 8'(k)) o_cmd_payload[8*k +: 8] <= i_rx_byte;
            end
            idx     <= idx + 8'd1;
            xor_acc <= xor_acc ^ i_rx_byte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
